delay_tap_calibrator: RTL and testbench

DELAY_TAP_CALIBRATOR -- requirements
Module: delay_tap_calibrator

---
 rtl/delay_cal_pkg.sv | 25 ++
 rtl/delay_cal_vote.sv | 68 ++++++
 rtl/delay_tap_calibrator.sv | 185 ++++++++++++++++++
 tb/tb_delay_tap_calibrator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_cal_pkg.sv
// Shared definitions for the delay-tap calibrator.
//   cal_state_e : sweep FSM state encoding
//   SelWDefault : default tap-select width (32 taps)
//   NSamp       : SAMPLE cycles per tap; 3 with majority voting, else 1
// Build option: define DELAY_CAL_MAJORITY_EN to enable 3-sample majority voting.
package delay_cal_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSet,
    StSettle,
    StSample,
    StEval,
    StFinish
  } cal_state_e;

  localparam int unsigned SelWDefault = 5;

`ifdef DELAY_CAL_MAJORITY_EN
  localparam int unsigned NSamp = 3;
`else
  localparam int unsigned NSamp = 1;
`endif

endpackage

// File: rtl/delay_cal_vote.sv
// Phase-detector sampler for the delay-tap calibrator.
// Counts sample over NSamp consecutive enabled cycles and registers the
// majority as tap_val; valid strobes for one cycle once tap_val is updated.
// Build option: DELAY_CAL_MAJORITY_EN (via delay_cal_pkg::NSamp).
// Ports:
//   clock, reset_n : block clock, asynchronous active-low reset
//   en             : high while the FSM is in SAMPLE
//   sample         : phase-detector bit, synchronous to clock
//   last           : combinational, high on the final SAMPLE cycle
//   valid          : one-cycle strobe the cycle after last
//   tap_val        : registered vote result
module delay_cal_vote
  import delay_cal_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic sample,
  output logic last,
  output logic valid,
  output logic tap_val
);

  logic [1:0] cnt_q, cnt_d;
  logic [1:0] ones_q, ones_d;
  logic [2:0] ones_sum;
  logic       tap_val_q, tap_val_d;
  logic       valid_q, valid_d;

  always_comb begin
    last      = en && (cnt_q == 2'(NSamp - 1));
    ones_sum  = {1'b0, ones_q} + {2'b00, sample};
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    tap_val_d = tap_val_q;
    valid_d   = last;
    if (!en) begin
      // Leaving SAMPLE (or an abort) restarts the count for the next tap.
      cnt_d  = '0;
      ones_d = '0;
    end else if (last) begin
      tap_val_d = (ones_sum >= 3'(NSamp / 2 + 1));
      cnt_d     = '0;
      ones_d    = '0;
    end else begin
      cnt_d  = cnt_q + 2'd1;
      ones_d = ones_sum[1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      ones_q    <= '0;
      tap_val_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      tap_val_q <= tap_val_d;
      valid_q   <= valid_d;
    end
  end

  assign valid   = valid_q;
  assign tap_val = tap_val_q;

endmodule

// File: rtl/delay_tap_calibrator.sv
// Delay-line tap calibrator. Sweeps sel from tap 0 upward, waits SETTLE_CYCLES
// after each change, samples the phase detector and stops at the first 0->1
// transition. On success sel = saturate(edge + tap_offset); on failure sel is
// restored to its pre-sweep value. manual_en overrides/aborts the sweep.
// Build option: DELAY_CAL_MAJORITY_EN selects 3-sample majority voting.
// Ports:
//   clock, reset_n        : block clock, asynchronous active-low reset
//   cal_start             : one-cycle calibration request (accepted in IDLE only)
//   manual_en, manual_sel : manual tap override
//   tap_offset            : offset added to the found edge tap
//   sample                : phase-detector result
//   sel                   : registered tap select to the delay buffer
//   cal_busy              : sweep in progress
//   cal_done              : one-cycle success pulse
//   cal_fail              : sticky failure flag, cleared by the next accepted start
//   cal_tap               : raw edge tap of the last successful sweep
module delay_tap_calibrator
  import delay_cal_pkg::*;
#(
  parameter int unsigned SEL_W         = SelWDefault,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cal_start,
  input  logic             manual_en,
  input  logic [SEL_W-1:0] manual_sel,
  input  logic [SEL_W-1:0] tap_offset,
  input  logic             sample,
  output logic [SEL_W-1:0] sel,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [SEL_W-1:0] cal_tap
);

  localparam logic [SEL_W-1:0] TapMax = '1;

  cal_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tap_idx_q, tap_idx_d;
  logic [SEL_W-1:0] hold_sel_q, hold_sel_d;
  logic [SEL_W-1:0] cal_tap_q, cal_tap_d;
  logic             seen_zero_q, seen_zero_d;
  logic             cal_fail_q, cal_fail_d;
  logic             ok_q, ok_d;
  logic [7:0]       settle_q, settle_d;

  logic             busy;
  logic             abort;
  logic             edge_found;
  logic             vote_last, vote_valid, tap_val;
  logic [SEL_W:0]   tap_sum;
  logic [SEL_W-1:0] tap_sat;

  delay_cal_vote u_vote (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state_q == StSample),
    .sample  (sample),
    .last    (vote_last),
    .valid   (vote_valid),
    .tap_val (tap_val)
  );

  assign busy       = (state_q == StSet) || (state_q == StSettle) ||
                      (state_q == StSample) || (state_q == StEval);
  assign abort      = busy && manual_en;
  // Tap 0 can never be an edge: a 0 must have been seen first.
  assign edge_found = tap_val && seen_zero_q;
  // One extra bit so the offset saturates instead of wrapping.
  assign tap_sum    = {1'b0, tap_idx_q} + {1'b0, tap_offset};
  assign tap_sat    = tap_sum[SEL_W] ? TapMax : tap_sum[SEL_W-1:0];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (!manual_en && cal_start) state_d = StSet;
        StSet:    state_d = StSettle;
        StSettle: if (settle_q == 8'(SETTLE_CYCLES - 1)) state_d = StSample;
        StSample: if (vote_last) state_d = StEval;
        StEval: begin
          if (vote_valid) begin
            if (edge_found || (tap_idx_q == TapMax)) state_d = StFinish;
            else                                     state_d = StSet;
          end
        end
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    cal_busy = busy;
    cal_done = (state_q == StFinish) && ok_q;
  end

  // Datapath next-state.
  always_comb begin
    sel_d       = sel_q;
    tap_idx_d   = tap_idx_q;
    hold_sel_d  = hold_sel_q;
    cal_tap_d   = cal_tap_q;
    seen_zero_d = seen_zero_q;
    cal_fail_d  = cal_fail_q;
    ok_d        = ok_q;
    settle_d    = (state_q == StSettle) ? settle_q + 8'd1 : 8'd0;
    if (!abort) begin
      unique case (state_q)
        StIdle: begin
          if (manual_en) begin
            sel_d = manual_sel;
          end else if (cal_start) begin
            hold_sel_d  = sel_q;
            tap_idx_d   = '0;
            seen_zero_d = 1'b0;
            cal_fail_d  = 1'b0;
          end
        end
        StSet: sel_d = tap_idx_q;
        StEval: begin
          if (vote_valid) begin
            if (edge_found) begin
              cal_tap_d = tap_idx_q;
              sel_d     = tap_sat;
              ok_d      = 1'b1;
            end else begin
              if (!tap_val) seen_zero_d = 1'b1;
              if (tap_idx_q == TapMax) begin
                sel_d      = hold_sel_q;
                cal_fail_d = 1'b1;
                ok_d       = 1'b0;
              end else begin
                tap_idx_d = tap_idx_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q       <= '0;
      tap_idx_q   <= '0;
      hold_sel_q  <= '0;
      cal_tap_q   <= '0;
      seen_zero_q <= 1'b0;
      cal_fail_q  <= 1'b0;
      ok_q        <= 1'b0;
      settle_q    <= '0;
    end else begin
      sel_q       <= sel_d;
      tap_idx_q   <= tap_idx_d;
      hold_sel_q  <= hold_sel_d;
      cal_tap_q   <= cal_tap_d;
      seen_zero_q <= seen_zero_d;
      cal_fail_q  <= cal_fail_d;
      ok_q        <= ok_d;
      settle_q    <= settle_d;
    end
  end

  assign sel      = sel_q;
  assign cal_fail = cal_fail_q;
  assign cal_tap  = cal_tap_q;

endmodule

// File: tb/tb_delay_tap_calibrator.sv
// Directed bench for delay_tap_calibrator. The phase detector is modelled as
// sample = (sel >= edge_tap) | glitch.
module tb_delay_tap_calibrator;
  import delay_cal_pkg::*;

  localparam int SelW   = 5;
  localparam int Settle = 8;
  localparam int PerTap = 2 + Settle + NSamp;

  logic            clock;
  logic            reset_n;
  logic            cal_start;
  logic            manual_en;
  logic [SelW-1:0] manual_sel;
  logic [SelW-1:0] tap_offset;
  logic            sample;
  logic [SelW-1:0] sel;
  logic            cal_busy;
  logic            cal_done;
  logic            cal_fail;
  logic [SelW-1:0] cal_tap;

  int   edge_tap;
  logic glitch;
  int   errors;
  int   checks;

  assign sample = (int'(sel) >= edge_tap) | glitch;

  delay_tap_calibrator #(
    .SEL_W         (SelW),
    .SETTLE_CYCLES (Settle)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cal_start  (cal_start),
    .manual_en  (manual_en),
    .manual_sel (manual_sel),
    .tap_offset (tap_offset),
    .sample     (sample),
    .sel        (sel),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_fail   (cal_fail),
    .cal_tap    (cal_tap)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues cal_start and follows the sweep to FINISH.
  task automatic run_sweep(input int budget, output int busy_n, output int done_n,
                           output int max_sel, output bit timed_out);
    cal_start = 1'b1;
    @(negedge clock);
    cal_start = 1'b0;
    busy_n    = 0;
    done_n    = 0;
    max_sel   = 0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (cal_done) done_n++;
      if (cal_busy) begin
        busy_n++;
        if (int'(sel) > max_sel) max_sel = int'(sel);
      end else begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clock);
    end
    if (!timed_out) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        if (cal_done) done_n++;
      end
    end
  endtask

  task automatic wait_sel(input int v, output bit found);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (cal_busy && int'(sel) == v) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit found);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!cal_busy) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    int busy_n, done_n, max_sel;
    bit timed_out, found;
    errors     = 0;
    checks     = 0;
    reset_n    = 1'b0;
    cal_start  = 1'b0;
    manual_en  = 1'b0;
    manual_sel = '0;
    tap_offset = '0;
    edge_tap   = 99;
    glitch     = 1'b0;

    repeat (2) @(negedge clock);
    check("reset_sel", 32'(sel), 0);
    check("reset_busy", 32'(cal_busy), 0);
    check("reset_done", 32'(cal_done), 0);
    check("reset_fail", 32'(cal_fail), 0);
    check("reset_tap", 32'(cal_tap), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Edge at tap 13, offset 2.
    edge_tap   = 13;
    tap_offset = 5'd2;
    run_sweep(600, busy_n, done_n, max_sel, timed_out);
    check("t1_timeout", 32'(timed_out), 0);
    check("t1_cal_tap", 32'(cal_tap), 13);
    check("t1_sel", 32'(sel), 15);
    check("t1_done_cnt", 32'(done_n), 1);
    check("t1_busy_cycles", 32'(busy_n), 32'(14 * PerTap));
    check("t1_fail", 32'(cal_fail), 0);

    // All taps sample 1: no 0->1 edge, sel restored to 7.
    manual_en  = 1'b1;
    manual_sel = 5'd7;
    repeat (2) @(negedge clock);
    check("t2_manual_sel", 32'(sel), 7);
    manual_en = 1'b0;
    edge_tap  = 0;
    run_sweep(600, busy_n, done_n, max_sel, timed_out);
    check("t2_timeout", 32'(timed_out), 0);
    check("t2_fail", 32'(cal_fail), 1);
    check("t2_sel", 32'(sel), 7);
    check("t2_done_cnt", 32'(done_n), 0);
    check("t2_max_tap", 32'(max_sel), 31);
    check("t2_busy_cycles", 32'(busy_n), 32'(32 * PerTap));
    check("t2_cal_tap_kept", 32'(cal_tap), 13);

    // Manual abort at tap 4.
    edge_tap  = 13;
    cal_start = 1'b1;
    @(negedge clock);
    cal_start = 1'b0;
    wait_sel(4, found);
    check("t4_reach_tap4", 32'(found), 1);
    manual_en  = 1'b1;
    manual_sel = 5'd9;
    @(negedge clock);
    check("t4_idle_busy", 32'(cal_busy), 0);
    check("t4_idle_done", 32'(cal_done), 0);
    @(negedge clock);
    check("t4_sel_manual", 32'(sel), 9);
    check("t4_done", 32'(cal_done), 0);
    check("t4_fail_kept", 32'(cal_fail), 0);
    check("t4_cal_tap_kept", 32'(cal_tap), 13);
    manual_en = 1'b0;
    repeat (2) @(negedge clock);
    check("t4_sel_hold", 32'(sel), 9);

    // Edge at 30, offset 5: saturates at 31.
    edge_tap   = 30;
    tap_offset = 5'd5;
    run_sweep(600, busy_n, done_n, max_sel, timed_out);
    check("t3_timeout", 32'(timed_out), 0);
    check("t3_cal_tap", 32'(cal_tap), 30);
    check("t3_sel_sat", 32'(sel), 31);
    check("t3_done_cnt", 32'(done_n), 1);

    // Reset during SETTLE of tap 2.
    edge_tap   = 13;
    tap_offset = 5'd0;
    cal_start  = 1'b1;
    @(negedge clock);
    cal_start = 1'b0;
    wait_sel(2, found);
    check("rst_reach_tap2", 32'(found), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_sel", 32'(sel), 0);
    check("rst_busy", 32'(cal_busy), 0);
    check("rst_done", 32'(cal_done), 0);
    check("rst_fail", 32'(cal_fail), 0);
    check("rst_cal_tap", 32'(cal_tap), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("rst_after_busy", 32'(cal_busy), 0);
      check("rst_after_done", 32'(cal_done), 0);
      check("rst_after_fail", 32'(cal_fail), 0);
    end
    // Start accepted on the first edge after release.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n   = 1'b1;
    cal_start = 1'b1;
    @(negedge clock);
    cal_start = 1'b0;
    check("rst_first_edge_busy", 32'(cal_busy), 1);
    wait_idle(found);
    check("rst_sweep_end", 32'(found), 1);
    check("rst_sweep_done", 32'(cal_done), 1);
    check("rst_sweep_tap", 32'(cal_tap), 13);
    check("rst_sweep_sel", 32'(sel), 13);

    // Single-cycle glitch on the first SAMPLE cycle of tap 5, true edge at 20.
    repeat (2) @(negedge clock);
    edge_tap  = 20;
    cal_start = 1'b1;
    @(negedge clock);
    cal_start = 1'b0;
    wait_sel(5, found);
    check("gl_reach_tap5", 32'(found), 1);
    repeat (Settle) @(negedge clock);
    glitch = 1'b1;
    @(negedge clock);
    glitch = 1'b0;
    wait_idle(found);
    check("gl_sweep_end", 32'(found), 1);
    check("gl_cal_tap", 32'(cal_tap), (NSamp == 3) ? 20 : 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
